// File: rtl/shift_add_mul_ctrl.sv
// Sequential unsigned multiplier: one add-and-shift step per clock through a
// block-carry adder. Result is {acc_hi, acc_lo} after bit_width iterations.

module fast_adder #(
  parameter int width        = 16,
  parameter int cascade_size = 4
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  input  logic             cin_i,
  output logic [width-1:0] sum_o,
  output logic             cout_o
);
  localparam int NBLK = width / cascade_size;

  logic [NBLK:0] carry;

  assign carry[0] = cin_i;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    assign {carry[g+1], sum_o[g*cascade_size +: cascade_size]} =
        {1'b0, a_i[g*cascade_size +: cascade_size]} +
        {1'b0, b_i[g*cascade_size +: cascade_size]} +
        {{cascade_size{1'b0}}, carry[g]};
  end

  assign cout_o = carry[NBLK];
endmodule

module shift_add_mul_ctrl #(
  parameter int bit_width    = 16,
  parameter int cascade_size = 4,
  localparam int IW          = $clog2(bit_width + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [bit_width-1:0]     op_a,
  input  logic [bit_width-1:0]     op_b,
  input  logic                     abort,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [2*bit_width-1:0]   product,
  output logic                     busy,
  output logic [IW-1:0]            iter
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid outputs are flops, never decoded from inputs.
  state_t                 state_q;
  logic [bit_width-1:0]   mcand_q;
  logic [bit_width-1:0]   acc_hi_q;
  logic [bit_width-1:0]   acc_lo_q;
  logic [IW-1:0]          iter_q;
  logic                   req_ready_q;
  logic                   resp_valid_q;
  logic                   busy_q;

  logic [bit_width-1:0]   addend;
  logic [bit_width-1:0]   sum_d;
  logic                   cout_d;

  assign addend = acc_lo_q[0] ? mcand_q : '0;

  fast_adder #(
    .width        (bit_width),
    .cascade_size (cascade_size)
  ) u_adder (
    .a_i    (acc_hi_q),
    .b_i    (addend),
    .cin_i  (1'b0),
    .sum_o  (sum_d),
    .cout_o (cout_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mcand_q      <= '0;
      acc_hi_q     <= '0;
      acc_lo_q     <= '0;
      iter_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            mcand_q     <= op_a;
            acc_hi_q    <= '0;
            acc_lo_q    <= op_b;
            iter_q      <= '0;
            state_q     <= RUN;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            mcand_q     <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            iter_q      <= '0;
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            // The carry-out lands in the top bit, so the shifted result is exact.
            acc_hi_q <= {cout_d, sum_d[bit_width-1:1]};
            acc_lo_q <= {sum_d[0], acc_lo_q[bit_width-1:1]};
            iter_q   <= iter_q + IW'(1);
            if (iter_q == IW'(bit_width - 1)) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (resp_ready || abort) begin
            iter_q       <= '0;
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign busy       = busy_q;
  assign iter       = iter_q;
  assign product    = {acc_hi_q, acc_lo_q};
endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Scoreboard bench for shift_add_mul_ctrl: accepted requests push a reference
// product; a response monitor pops and compares on every handoff.

module tb_shift_add_mul_ctrl;
  localparam int W  = 16;
  localparam int IW = $clog2(W + 1);

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic            abort;
  logic            resp_valid;
  logic            resp_ready;
  logic [2*W-1:0]  product;
  logic            busy;
  logic [IW-1:0]   iter;

  shift_add_mul_ctrl #(.bit_width(W), .cascade_size(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .abort      (abort),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .product    (product),
    .busy       (busy),
    .iter       (iter)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];
  int             acc_edge_q[$];
  int             vectors     = 0;
  int             miscompares = 0;
  logic           prev_rv     = 1'b0;
  bit             rr_rand     = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] wa;
    logic [2*W-1:0] wb;
    wa = {{W{1'b0}}, a};
    wb = {{W{1'b0}}, b};
    return wa * wb;
  endfunction

  // Request monitor: an accept happens on the edge following a negedge where
  // req_valid and req_ready are both high.
  initial forever begin
    @(negedge clk); #1;
    if (rst_n && req_valid && req_ready) begin
      check("accept_only_idle", {62'd0, busy, resp_valid}, 64'd0);
      exp_q.push_back(ref_mul(op_a, op_b));
      acc_edge_q.push_back(cyc + 1);
    end
  end

  // Response monitor: latency on the rising edge of resp_valid, data on handoff.
  initial forever begin
    @(negedge clk); #1;
    if (!rst_n) begin
      prev_rv = 1'b0;
    end else begin
      if (resp_valid && !prev_rv) begin
        if (acc_edge_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_resp_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          // Edges counted from the accept edge inclusive.
          check("latency_edges", 64'(cyc - acc_edge_q.pop_front() + 1), 64'(W + 1));
        end
      end
      prev_rv = resp_valid;
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_handoff: got 0x%0h expected none", product);
        end else begin
          check("product", 64'(product), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rr_rand) resp_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    int n = 0;
    op_a = a; op_b = b; req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      @(negedge clk); n++;
    end
    if (!req_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1");
    end
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!resp_valid && n < 100) begin
      @(negedge clk); n++;
    end
    if (!resp_valid) begin
      vectors++; miscompares++;
      $display("FAIL resp_timeout: got resp_valid=0 expected 1");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk); n++;
    end
    check("return_idle", 64'(req_ready), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] held;

    rst_n = 1'b0; req_valid = 1'b0; op_a = '0; op_b = '0;
    abort = 1'b0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_iter", 64'(iter), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 3 x 5
    issue(16'd3, 16'd5, 1'b0);
    check("req_ready_drops", 64'(req_ready), 64'd0);
    check("busy_in_run", 64'(busy), 64'd1);
    wait_resp();
    check("basic_product", 64'(product), 64'h0000000F);
    @(negedge clk);
    check("resp_valid_after_handoff", 64'(resp_valid), 64'd0);
    wait_idle();

    // Carry-out propagation and zero multiplier
    issue(16'hFFFF, 16'hFFFF, 1'b0);
    wait_resp();
    check("ones_product", 64'(product), 64'hFFFE0001);
    @(negedge clk); wait_idle();
    issue(16'h1234, 16'h0000, 1'b0);
    wait_resp();
    check("zero_product", 64'(product), 64'd0);
    @(negedge clk); wait_idle();

    // Backpressure
    resp_ready = 1'b0;
    issue(16'h00FF, 16'h0100, 1'b0);
    wait_resp();
    held = 32'h0000FF00;
    for (int i = 0; i < 10; i++) begin
      check("bp_resp_valid", 64'(resp_valid), 64'd1);
      check("bp_product", 64'(product), 64'(held));
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_handoff", 64'(resp_valid), 64'd0);
    wait_idle();

    // Abort during RUN at iteration 5
    issue(16'd7, 16'd9, 1'b0);
    n = 0;
    while (iter != IW'(5) && n < 40) begin
      @(negedge clk); n++;
    end
    check("abort_iter_reached", 64'(iter), 64'd5);
    abort = 1'b1;
    void'(exp_q.pop_back());
    void'(acc_edge_q.pop_back());
    @(negedge clk);
    abort = 1'b0;
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_product_cleared", 64'(product), 64'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) n++;
      @(negedge clk);
    end
    check("abort_no_resp", 64'(n), 64'd0);
    issue(16'd2, 16'd3, 1'b0);
    wait_resp();
    check("post_abort_product", 64'(product), 64'd6);
    @(negedge clk); wait_idle();

    // Abort in DONE while the consumer stalls
    resp_ready = 1'b0;
    issue(16'd100, 16'd200, 1'b0);
    wait_resp();
    abort = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    abort = 1'b0;
    check("done_abort_resp_valid", 64'(resp_valid), 64'd0);
    check("done_abort_req_ready", 64'(req_ready), 64'd1);
    resp_ready = 1'b1;

    // Asynchronous reset in the middle of RUN
    issue(16'h1234, 16'h5678, 1'b0);
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_busy", 64'(busy), 64'd0);
    check("async_req_ready", 64'(req_ready), 64'd1);
    check("async_product", 64'(product), 64'd0);
    exp_q.delete();
    acc_edge_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'h8000, 16'd2, 1'b0);
    wait_resp();
    check("post_reset_product", 64'(product), 64'h00010000);
    @(negedge clk); wait_idle();

    // Back-to-back randomized requests, req_valid held high
    rr_rand = 1'b1;
    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 5))
        0: begin ra = '1; rb = W'($urandom); end
        1: begin ra = W'($urandom); rb = '0; end
        default: begin ra = W'($urandom); rb = W'($urandom); end
      endcase
      issue(ra, rb, 1'b1);
    end
    req_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    rr_rand = 1'b0;
    resp_ready = 1'b1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
